vga_capture: RTL and testbench
==============================

# vga_capture

Frame grabber on the receive side of the VGA pixel interface. It samples the sync, blank and RGB signals produced by the display path and rebuilds pixel coordinates from them. It then issues one write per visible pixel into a 24-bit frame memory, using the same packed address layout the display path reads: {x[9:0], y[8:0]}. It sits in the simulation and verification harness beside the VGA output, so that a driven frame can be loop-checked against the source image.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.

Ports:
- clk  in  1  pixel clock; the same clock that drives the VGA output.
- rst  in  1  synchronous, active-high reset.
- vga_hsync  in  1  horizontal sync, active low.
- vga_vsync  in  1  vertical sync, active low.
- vga_blank_n  in  1  high during visible pixels.
- vga_r, vga_g, vga_b  in  8 each  pixel colour.
- wr_en  out  1  frame-memory write strobe, one cycle per pixel.
- wr_addr  out  19  {x[9:0], y[8:0]}.
- wr_data  out  24  {r, g, b}.
- frame_done  out  1  one-cycle pulse after the last pixel of a complete frame.
- frame_cnt  out  16  count of complete frames captured; wraps at 0xFFFF -> 0.
- locked  out  1  high while the block is tracking a valid frame sequence.
- err  out  1  sticky protocol-error flag; cleared only by rst.

## Operation
- Input stage:
  - All VGA inputs are registered once (stage S1).
  - Edge detection compares S1 with a second register, S2.
  - vsync_fall = S2 high and S1 low; blank_rise and blank_fall are defined the same way on blank_n.
- Counters:
  - x counts pixels within a line, 10 bits.
  - y counts lines within a frame, 9 bits.
  - pix_in_line counts blank_n-high cycles in the current line, 11 bits, saturating at 2047.
- States:
  - IDLE: the state after reset. Leave on vsync_fall -> ARMED; set y = 0.
  - ARMED: wait for the first blank_rise -> CAPTURE; set x = 0.
  - CAPTURE:
    - Each S1 cycle with blank_n high and x < H_ACTIVE writes a pixel: wr_en = 1, wr_addr = {x, y}, wr_data = {r, g, b}; then x increments.
    - Pixels with x >= H_ACTIVE are not written.
    - On blank_fall:
      - If pix_in_line != H_ACTIVE, set err, clear locked, go to IDLE.
      - Otherwise y increments, and x and pix_in_line clear.
      - If y was V_ACTIVE-1: pulse frame_done, increment frame_cnt, set locked, go to IDLE to wait for the next vsync.
    - A vsync_fall while in CAPTURE (short frame) sets err, clears locked, and goes to ARMED with y = 0.
- hsync is not used for addressing. An hsync falling edge in CAPTURE while blank_n is high sets err. The line is finished normally.
- Addresses are never written outside x < H_ACTIVE and y < V_ACTIVE.

## Timing
- Reset values:
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - frame_done = 0, frame_cnt = 0, locked = 0, err = 0.
  - State = IDLE; all counters 0; S1 and S2 = 1 for the syncs, 0 for blank_n and RGB.
- rst has priority over every event. Asserting it mid-frame aborts the frame immediately: no further writes, and frame_done is not pulsed.
- Latency is 2 cycles from input to output:
  - An input pixel present at clock edge N is captured into S1 at N.
  - The corresponding wr_en, wr_addr and wr_data are driven from edge N+1, so they are valid between edges N+1 and N+2.
- frame_done and the frame_cnt update appear in the same cycle, one cycle after the wr_en of the last pixel.
- If blank_fall and vsync_fall are decoded in the same cycle: the line-end check runs first, then the vsync rule applies.
- Back-to-back frames need no gap beyond the normal vsync interval.

## Configuration
- VGA_CAPTURE_CRC_EN:
  - Defined: adds an output, frame_crc, 32 bits.
  - The CRC-32 runs over wr_data, 24 bits per written pixel, little-endian bit order, polynomial 0x04C11DB7.
  - Seed 0xFFFFFFFF at each frame start; the result is inverted at the end of the frame.
  - frame_crc is registered and updated in the same cycle as frame_done; its reset value is 0.
  - Not defined: the port and all related logic are absent. Nothing else changes.

## Test plan
- 640x480 standard timing (800x525 total), pixel = {x[7:0], y[7:0], 8'h5A}:
  - Exactly 307200 writes.
  - Write to {10'd639, 9'd479} with data {8'h7F, 8'hDF, 8'h5A}.
  - One frame_done; frame_cnt = 1; locked = 1; err = 0.
- Line 100 driven with 641 visible pixels:
  - Pixel x = 640 is not written.
  - err = 1 and locked = 0 at that line's blank_fall.
  - No frame_done until the next clean frame; after it, frame_cnt = 1.
- vsync asserted after 200 lines:
  - err = 1; no frame_done; the next full frame gives frame_cnt = 1.
- rst asserted at pixel (320, 240):
  - All outputs 0 the next cycle; no writes until a fresh vsync and frame.
- Three consecutive clean frames -> frame_cnt = 3, with three frame_done pulses spaced 420000 cycles apart.
- With VGA_CAPTURE_CRC_EN defined and an all-zero frame:
  - frame_crc equals the reference CRC-32 over 921600 zero bytes.
  - An identical second frame gives an identical value.

Source files
------------

// File: rtl/vga_capture.sv
// VGA receive-side frame grabber: rebuilds pixel coordinates from sync/blank and writes visible pixels as {x,y}.
// Optional VGA_CAPTURE_CRC_EN adds a per-frame CRC-32 of the written pixel data on frame_crc.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        locked,
`ifdef VGA_CAPTURE_CRC_EN
  output logic [31:0] frame_crc,
`endif
  output logic        err
);

  localparam logic [9:0]  X_LIM   = 10'(H_ACTIVE);
  localparam logic [8:0]  Y_LIM   = 9'(V_ACTIVE);
  localparam logic [8:0]  Y_LAST  = 9'(V_ACTIVE - 1);
  localparam logic [10:0] PIX_LIM = 11'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  // Reflected CRC-32 (poly 0x04C11DB7), wr_data bit 0 first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [23:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 24; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic        hs_p1, vs_p1, bl_p1;
  logic [7:0]  r_p1, g_p1, b_p1;
  logic        hs_p2, vs_p2, bl_p2;

  state_t      state, state_nxt;
  logic [9:0]  x, x_nxt;
  logic [8:0]  y, y_nxt;
  logic [10:0] pix, pix_nxt;
  logic        wr_nxt, done_nxt, lock_nxt, err_nxt, crc_seed;
  logic [15:0] cnt_nxt;

  logic vsync_fall, hsync_fall, blank_rise, blank_fall, in_line, frame_end;

  assign vsync_fall = vs_p2 & ~vs_p1;
  assign hsync_fall = hs_p2 & ~hs_p1;
  assign blank_rise = ~bl_p2 & bl_p1;
  assign blank_fall = bl_p2 & ~bl_p1;
  // ARMED joins the line on the very cycle the first visible pixel arrives.
  assign in_line = ~vsync_fall &
                   ((state == CAPTURE) || (state == ARMED && blank_rise));

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    pix_nxt   = pix;
    wr_nxt    = 1'b0;
    done_nxt  = 1'b0;
    cnt_nxt   = frame_cnt;
    lock_nxt  = locked;
    err_nxt   = err;
    crc_seed  = 1'b0;
    frame_end = 1'b0;

    if (state != CAPTURE && vsync_fall) begin
      state_nxt = ARMED;
      x_nxt     = '0;
      y_nxt     = '0;
      pix_nxt   = '0;
      crc_seed  = 1'b1;
    end

    if (in_line) begin
      state_nxt = CAPTURE;
      if (bl_p1) begin
        pix_nxt = sat_inc11(pix);
        if (x < X_LIM && y < Y_LIM) begin
          wr_nxt = 1'b1;
          x_nxt  = x + 10'd1;
        end
      end
      if (state == CAPTURE && hsync_fall && bl_p1) err_nxt = 1'b1;
    end

    if (state == CAPTURE && blank_fall) begin
      x_nxt   = '0;
      pix_nxt = '0;
      if (pix != PIX_LIM) begin
        err_nxt   = 1'b1;
        lock_nxt  = 1'b0;
        state_nxt = IDLE;
      end else if (y == Y_LAST) begin
        done_nxt  = 1'b1;
        cnt_nxt   = frame_cnt + 16'd1;
        lock_nxt  = 1'b1;
        frame_end = 1'b1;
        y_nxt     = '0;
        state_nxt = IDLE;
      end else begin
        y_nxt = y + 9'd1;
      end
    end

    // vsync inside a frame restarts capture; it is only an error if the frame was short.
    if (state == CAPTURE && vsync_fall) begin
      if (!frame_end) begin
        err_nxt  = 1'b1;
        lock_nxt = 1'b0;
      end
      state_nxt = ARMED;
      x_nxt     = '0;
      y_nxt     = '0;
      pix_nxt   = '0;
      crc_seed  = 1'b1;
    end
  end

  // Stage p1/p2: input registers and edge history; output stage: write port
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_p1      <= 1'b1;
      vs_p1      <= 1'b1;
      bl_p1      <= 1'b0;
      r_p1       <= '0;
      g_p1       <= '0;
      b_p1       <= '0;
      hs_p2      <= 1'b1;
      vs_p2      <= 1'b1;
      bl_p2      <= 1'b0;
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      pix        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      hs_p1      <= vga_hsync;
      vs_p1      <= vga_vsync;
      bl_p1      <= vga_blank_n;
      r_p1       <= vga_r;
      g_p1       <= vga_g;
      b_p1       <= vga_b;
      hs_p2      <= hs_p1;
      vs_p2      <= vs_p1;
      bl_p2      <= bl_p1;
      state      <= state_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      pix        <= pix_nxt;
      wr_en      <= wr_nxt;
      wr_addr    <= {x, y};
      wr_data    <= {r_p1, g_p1, b_p1};
      frame_done <= done_nxt;
      frame_cnt  <= cnt_nxt;
      locked     <= lock_nxt;
      err        <= err_nxt;
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  logic [31:0] crc_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_acc   <= 32'hFFFFFFFF;
      frame_crc <= '0;
    end else begin
      if (crc_seed)    crc_acc <= 32'hFFFFFFFF;
      else if (wr_nxt) crc_acc <= crc_step(crc_acc, {r_p1, g_p1, b_p1});
      if (done_nxt)    frame_crc <= ~crc_acc;
    end
  end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 8x4 raster (14x7 total) with hand-derived expectations.
module tb_vga_capture;
  localparam int H = 8;
  localparam int V = 4;
  localparam int H_TOTAL = 14;
  localparam int V_TOTAL = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vga_hsync = 1'b1, vga_vsync = 1'b1, vga_blank_n = 1'b0;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        wr_en, frame_done, locked, err;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic [15:0] frame_cnt;
`ifdef VGA_CAPTURE_CRC_EN
  logic [31:0] frame_crc;
`endif

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .locked(locked),
`ifdef VGA_CAPTURE_CRC_EN
    .frame_crc(frame_crc),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int writes   = 0;
  int dones    = 0;
  int cyc      = 0;
  int done_cyc [3];
  logic [18:0] last_addr;
  logic [23:0] last_data;
  bit zero_pix = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (wr_en) begin
      writes++;
      last_addr = wr_addr;
      last_data = wr_data;
      check("wr_in_range", 64'((wr_addr[18:9] < H) && (wr_addr[8:0] < V)), 64'd1);
      check("wr_data", 64'(wr_data),
            zero_pix ? 64'd0 : 64'({wr_addr[16:9], wr_addr[7:0], 8'h5A}));
    end
    if (frame_done) begin
      if (dones < 3) done_cyc[dones] = cyc;
      dones++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_done"}, 64'(frame_done), 64'd0);
    check({tag, "_cnt"}, 64'(frame_cnt), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    vga_hsync = 1'b1; vga_vsync = 1'b1; vga_blank_n = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    writes = 0;
    dones  = 0;
  endtask

  // Line 0 is vsync, line 1 back porch, lines 2..5 active, line 6 front porch.
  // Each line: active pixels first, then porch with hsync low at h = 10..11.
  task automatic drive_frame(input int bad_line, input int stop_after,
                             input int rst_line, input int rst_x);
    bit rst_pending = 1'b0;
    for (int l = 0; l < V_TOTAL; l++) begin
      int a = l - 2;
      if (stop_after >= 0 && a == stop_after) return;
      for (int h = 0; h < H_TOTAL; h++) begin
        @(negedge clk);
        if (rst_pending) begin
          check_all_zero("mid_rst");
          writes = 0;
          rst_pending = 1'b0;
        end
        vga_vsync   = (l != 0);
        vga_hsync   = !(h >= 10 && h < 12);
        vga_blank_n = (a >= 0 && a < V) && (h < H || (a == bad_line && h == H));
        vga_r = zero_pix ? 8'd0 : 8'(h);
        vga_g = zero_pix ? 8'd0 : 8'(a);
        vga_b = zero_pix ? 8'd0 : 8'h5A;
        rst = (a == rst_line && h == rst_x);
        if (rst) rst_pending = 1'b1;
      end
    end
  endtask

`ifdef VGA_CAPTURE_CRC_EN
  function automatic logic [31:0] crc_zero_bytes(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n * 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction
`endif

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    writes = 0;

    // One clean frame
    drive_frame(-1, -1, -1, -1);
    check("clean_writes", 64'(writes), 64'(H * V));
    check("clean_last_addr", 64'(last_addr), 64'({10'd7, 9'd3}));
    check("clean_last_data", 64'(last_data), 64'({8'h07, 8'h03, 8'h5A}));
    check("clean_dones", 64'(dones), 64'd1);
    check("clean_cnt", 64'(frame_cnt), 64'd1);
    check("clean_locked", 64'(locked), 64'd1);
    check("clean_err", 64'(err), 64'd0);

    // Active line 1 carries one extra visible pixel
    do_reset();
    drive_frame(1, -1, -1, -1);
    check("long_writes", 64'(writes), 64'(H + H));
    check("long_err", 64'(err), 64'd1);
    check("long_locked", 64'(locked), 64'd0);
    check("long_dones", 64'(dones), 64'd0);
    drive_frame(-1, -1, -1, -1);
    check("long_next_cnt", 64'(frame_cnt), 64'd1);
    check("long_next_dones", 64'(dones), 64'd1);
    check("long_next_locked", 64'(locked), 64'd1);
    check("long_err_sticky", 64'(err), 64'd1);

    // vsync arrives after two active lines
    do_reset();
    drive_frame(-1, 2, -1, -1);
    check("short_dones", 64'(dones), 64'd0);
    check("short_writes", 64'(writes), 64'(2 * H));
    drive_frame(-1, -1, -1, -1);
    check("short_err", 64'(err), 64'd1);
    check("short_next_cnt", 64'(frame_cnt), 64'd1);
    check("short_next_dones", 64'(dones), 64'd1);

    // Reset at pixel (4, 2)
    do_reset();
    drive_frame(-1, -1, 2, 4);
    check("rst_no_writes", 64'(writes), 64'd0);
    check("rst_no_done", 64'(dones), 64'd0);
    check("rst_cnt", 64'(frame_cnt), 64'd0);
    writes = 0;
    drive_frame(-1, -1, -1, -1);
    check("rst_next_writes", 64'(writes), 64'(H * V));
    check("rst_next_cnt", 64'(frame_cnt), 64'd1);

    // Three back-to-back frames
    do_reset();
    for (int f = 0; f < 3; f++) drive_frame(-1, -1, -1, -1);
    check("b2b_cnt", 64'(frame_cnt), 64'd3);
    check("b2b_dones", 64'(dones), 64'd3);
    check("b2b_gap1", 64'(done_cyc[1] - done_cyc[0]), 64'(H_TOTAL * V_TOTAL));
    check("b2b_gap2", 64'(done_cyc[2] - done_cyc[1]), 64'(H_TOTAL * V_TOTAL));
    check("b2b_writes", 64'(writes), 64'(3 * H * V));

`ifdef VGA_CAPTURE_CRC_EN
    do_reset();
    zero_pix = 1'b1;
    drive_frame(-1, -1, -1, -1);
    check("crc_frame1", 64'(frame_crc), 64'(crc_zero_bytes(H * V * 3)));
    drive_frame(-1, -1, -1, -1);
    check("crc_frame2", 64'(frame_crc), 64'(crc_zero_bytes(H * V * 3)));
    zero_pix = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
